// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  function automatic logic op_is_div(input op_e o);
    return o == OP_DIV || o == OP_DIVU;
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return o == OP_MULT || o == OP_DIV;
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate of a 2W-bit value; the low W bits double
// as the magnitude when the input is a sign-extended or zero-extended W-bit word.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic           neg,
  input  logic [2*W-1:0] value,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   mag
);

  assign result = neg ? ((2*W)'(0) - value) : value;
  assign mag    = result[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add / restoring shift-subtract
// steps on magnitudes, followed by one sign-fix cycle that writes hi/lo.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hilo_we,
  input  logic         hilo_sel,
  input  logic [W-1:0] hilo_wdata,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             sign_a, sign_b;
  logic [W-1:0]     a_orig;
  logic [W-1:0]     opnd;       // multiplicand or divisor magnitude
  logic [2*W-1:0]   acc;        // product accumulator, or dividend/quotient in low half
  logic [W:0]       rem;        // partial remainder

  op_e  op_in;
  logic load_signed, load_div;
  assign op_in       = op_e'(op);
  assign load_signed = op_is_signed(op_in);
  assign load_div    = op_is_div(op_in);

  logic [2*W-1:0] a_full, b_full, res_full, rem_full, res_value;
  logic [W-1:0]   a_mag, b_mag, res_mag, rem_mag;

  md_sign_fix #(.W(W)) u_fix_a (
    .neg(load_signed & a[W-1]), .value({{W{1'b0}}, a}), .result(a_full), .mag(a_mag)
  );
  md_sign_fix #(.W(W)) u_fix_b (
    .neg(load_signed & b[W-1]), .value({{W{1'b0}}, b}), .result(b_full), .mag(b_mag)
  );

  // Product and quotient share one negator: both flip when the operand signs differ.
  assign res_value = is_div_q ? {{W{1'b0}}, acc[W-1:0]} : acc;
  md_sign_fix #(.W(W)) u_fix_res (
    .neg(sign_a ^ sign_b), .value(res_value), .result(res_full), .mag(res_mag)
  );
  md_sign_fix #(.W(W)) u_fix_rem (
    .neg(sign_a), .value({{W{1'b0}}, rem[W-1:0]}), .result(rem_full), .mag(rem_mag)
  );

  logic unused_bits;
  assign unused_bits = ^{a_full[2*W-1:W], b_full[2*W-1:W], res_mag,
                         rem_full[2*W-1:W], rem[W]};

  // One iteration of each algorithm.
  logic [W:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign div_shift = {rem[W-1:0], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RUN;
      end
      RUN:     if (cnt == LAST_ITER) state_d = FIX;
      FIX:     state_d = IDLE;
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt         <= '0;
      is_div_q    <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      a_orig      <= '0;
      opnd        <= '0;
      acc         <= '0;
      rem         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
          if (start) begin
            is_div_q <= load_div;
            sign_a   <= load_signed & a[W-1];
            sign_b   <= load_signed & b[W-1];
            a_orig   <= a;
            opnd     <= load_div ? b_mag : a_mag;
            acc      <= {{W{1'b0}}, (load_div ? a_mag : b_mag)};
            rem      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div_q) begin
            rem <= div_diff[W] ? div_shift : div_diff;
            acc <= {acc[2*W-1:W], acc[W-2:0], ~div_diff[W]};
          end else begin
            acc <= {mul_sum, acc[W-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_div_q && opnd == '0) begin
            lo          <= '1;
            hi          <= a_orig;
            div_by_zero <= 1'b1;
          end else if (is_div_q) begin
            lo <= res_full[W-1:0];
            hi <= rem_mag;
          end else begin
            {hi, lo} <= res_full;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hilo_we, hilo_sel;
  logic [W-1:0] hilo_wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.W(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Architectural result of one operation, from ordinary integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sx, sy, q, r;
    logic [63:0] p;
    edz = 1'b0;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy;                  {eh, el} = p; end
      2'b01: begin p = {32'b0, x} * {32'b0, y};  {eh, el} = p; end
      default: begin
        if (y == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = x; edz = 1'b1;
        end else if (o == 2'b11) begin
          el = x / y; eh = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endtask

  // Runs one operation; inject>0 pulses start(DIV)+MTHI after that many busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag, input int inject);
    logic [31:0] eh, el;
    logic        edz, dz;
    int          busy_n, done_at;
    model(o, x, y, eh, el, edz);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    busy_n  = int'(busy);
    done_at = 0;
    dz      = 1'b0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      @(posedge clock); #1;
      start = 1'b0; hilo_we = 1'b0;
      if (done) begin
        done_at = i;
        dz      = div_by_zero;
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      end else if (busy) begin
        busy_n++;
      end
      if (i == inject) begin
        start = 1'b1; op = 2'b10; hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234;
      end
    end
    check({tag, " latency"}, 64'(done_at), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    check({tag, " div_by_zero"}, 64'(dz), 64'(edz));
    m_hi = eh; m_lo = el;
    @(posedge clock); #1;
    check({tag, " done_single"}, 64'(done), 64'd0);
    check({tag, " idle_after"}, 64'(busy), 64'd0);
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] data, input string tag);
    hilo_we = 1'b1; hilo_sel = sel; hilo_wdata = data;
    @(posedge clock); #1;
    hilo_we = 1'b0;
    if (sel) m_hi = data; else m_lo = data;
    check({tag, " no_done"}, 64'(done), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'({done, div_by_zero}), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         "mult_neg",  -1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min",  -1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_neg",   -1);
    run_op(2'b11, 32'd100,       32'd7,         "divu",      -1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",   -1);
    run_op(2'b11, 32'd5,         32'd0,         "divu_zero", -1);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0,         "div_zero",  -1);

    // Start and MTHI during RUN must both be dropped.
    run_op(2'b01, 32'd3, 32'd4, "busy_hazard", 5);
    mt_write(1'b0, 32'h0000_ABCD, "mtlo_idle");

    // Asynchronous reset part-way through an operation.
    start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("midreset no_done", 64'(dones), 64'd0);
    run_op(2'b01, 32'd2, 32'd3, "after_reset", -1);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] x, y;
      if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), $urandom, "rand_mt");
      x = pick();
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_op(2'($urandom_range(0, 3)), x, y, $sformatf("rand%0d", n), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
